// File: rtl/pattern_pulse_gen.sv
// Programmable serial pulse-pattern generator.
// Emits a latched pattern LSB first, each bit held div+1 clocks.
module pattern_pulse_gen #(
    parameter int PATTERN_W = 16,
    parameter int DIV_W     = 8,
    parameter int LEN_W     = $clog2(PATTERN_W + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [LEN_W-1:0]     length_in,
    input  logic [DIV_W-1:0]     div_in,
    input  logic                 repeat_in,
    input  logic                 start,
    input  logic                 stop,
    output logic                 signal,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     bit_index
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PATTERN_W);

    state_t               state_q, state_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]     length_q, length_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 repeat_q, repeat_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic                 signal_q, signal_d;
    logic                 done_q, done_d;

    logic                 cfg_we;
    logic                 go;
    logic [LEN_W-1:0]     eff_len;
    logic [LEN_W-1:0]     nxt_idx;
    logic [PATTERN_W-1:0] nxt_shift;
    logic                 expire;
    logic                 last;

    always_comb begin
        cfg_we  = (state_q == IDLE) && load;
        go      = (state_q == IDLE) && start && !stop;
        eff_len = length_q;
        if ((length_q == '0) || (length_q >= FULL_LEN)) begin
            eff_len = FULL_LEN;
        end
        expire    = (cnt_q == '0);
        last      = (idx_q == (eff_len - 1'b1));
        nxt_idx   = idx_q + 1'b1;
        nxt_shift = pattern_q >> nxt_idx;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (expire && last && !repeat_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q == RUN);
        signal    = signal_q;
        done      = done_q;
        bit_index = idx_q;
    end

    // Config, counter and bit datapath
    always_comb begin
        pattern_d = cfg_we ? pattern_in : pattern_q;
        length_d  = cfg_we ? length_in  : length_q;
        div_d     = cfg_we ? div_in     : div_q;
        repeat_d  = cfg_we ? repeat_in  : repeat_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        signal_d  = signal_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                idx_d    = '0;
                signal_d = 1'b0;
                // A same-cycle load feeds straight into this run
                if (go) begin
                    cnt_d    = div_d;
                    signal_d = pattern_d[0];
                end
            end
            RUN: begin
                if (stop) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    signal_d = 1'b0;
                end else if (!expire) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!last) begin
                    cnt_d    = div_q;
                    idx_d    = nxt_idx;
                    signal_d = nxt_shift[0];
                end else if (repeat_q) begin
                    cnt_d    = div_q;
                    idx_d    = '0;
                    signal_d = pattern_q[0];
                end else begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    signal_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                cnt_d    = '0;
                idx_d    = '0;
                signal_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= '0;
            length_q  <= '0;
            div_q     <= '0;
            repeat_q  <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            signal_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            length_q  <= length_d;
            div_q     <= div_d;
            repeat_q  <= repeat_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            signal_q  <= signal_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_pulse_gen.sv
// Directed bench for pattern_pulse_gen.
// Expected sequences are hand-derived from the pattern and divider.
module tb_pattern_pulse_gen;

    localparam int PATTERN_W = 16;
    localparam int DIV_W     = 8;
    localparam int LEN_W     = 5;

    logic                 clock;
    logic                 reset_n;
    logic                 load;
    logic [PATTERN_W-1:0] pattern_in;
    logic [LEN_W-1:0]     length_in;
    logic [DIV_W-1:0]     div_in;
    logic                 repeat_in;
    logic                 start;
    logic                 stop;
    logic                 signal;
    logic                 busy;
    logic                 done;
    logic [LEN_W-1:0]     bit_index;

    int n_pass;
    int n_total;

    pattern_pulse_gen #(
        .PATTERN_W(PATTERN_W),
        .DIV_W    (DIV_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .pattern_in(pattern_in),
        .length_in (length_in),
        .div_in    (div_in),
        .repeat_in (repeat_in),
        .start     (start),
        .stop      (stop),
        .signal    (signal),
        .busy      (busy),
        .done      (done),
        .bit_index (bit_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [15:0] p, input logic [4:0] l,
                           input logic [7:0] d, input logic r);
        load       = 1'b1;
        pattern_in = p;
        length_in  = l;
        div_in     = d;
        repeat_in  = r;
        tick();
        load       = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_total++;
        if ({signal, busy, done, bit_index} !== 8'h00)
            $display("FAIL reset_outs: got %b want 0", {signal, busy, done, bit_index});
        else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_oneshot();
        logic [15:0] p;
        p = 16'h0015;
        do_load(p, 5'd6, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (signal !== p[i] || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL oneshot_bit%0d: got s=%b b=%b d=%b want s=%b b=1 d=0",
                         i, signal, busy, done, p[i]);
            else n_pass++;
            tick();
        end
        n_total++;
        if (signal !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL oneshot_done: got s=%b d=%b b=%b want 0 1 0", signal, done, busy);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL oneshot_after: got d=%b b=%b want 0 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_divider();
        logic [15:0] p;
        p = 16'h0015;
        do_load(p, 5'd6, 8'd3, 1'b0);
        do_start();
        for (int i = 0; i < 24; i++) begin
            n_total++;
            if (signal !== p[i/4] || bit_index !== 5'(i/4) || done !== 1'b0)
                $display("FAIL div_cyc%0d: got s=%b idx=%0d d=%b want s=%b idx=%0d d=0",
                         i, signal, bit_index, done, p[i/4], i/4);
            else n_pass++;
            tick();
        end
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL div_done: got d=%b b=%b want 1 0", done, busy);
        else n_pass++;
        tick();
    endtask

    task automatic test_repeat();
        logic [15:0] p;
        p = 16'h0005;
        do_load(p, 5'd3, 8'd0, 1'b1);
        do_start();
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (signal !== p[i%3] || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL repeat_cyc%0d: got s=%b b=%b d=%b want s=%b b=1 d=0",
                         i, signal, busy, done, p[i%3]);
            else n_pass++;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_total++;
        if ({signal, busy, done, bit_index} !== 8'h00)
            $display("FAIL repeat_stop: got %b want 0", {signal, busy, done, bit_index});
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL repeat_stop_after: got d=%b b=%b want 0 0", done, busy);
        else n_pass++;
    endtask

    task automatic test_length();
        logic [15:0] pats [3];
        logic [4:0]  lens [3];
        int          nbit [3];
        pats = '{16'hA5A5, 16'hA5A5, 16'h0001};
        lens = '{5'd0, 5'd20, 5'd1};
        nbit = '{16, 16, 1};
        for (int c = 0; c < 3; c++) begin
            logic [15:0] p;
            p = pats[c];
            do_load(p, lens[c], 8'd0, 1'b0);
            do_start();
            for (int i = 0; i < nbit[c]; i++) begin
                n_total++;
                if (signal !== p[i] || bit_index !== 5'(i) || done !== 1'b0)
                    $display("FAIL len%0d_bit%0d: got s=%b idx=%0d d=%b want s=%b idx=%0d d=0",
                             lens[c], i, signal, bit_index, done, p[i], i);
                else n_pass++;
                tick();
            end
            n_total++;
            if (done !== 1'b1 || signal !== 1'b0 || busy !== 1'b0)
                $display("FAIL len%0d_done: got d=%b s=%b b=%b want 1 0 0",
                         lens[c], done, signal, busy);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_ignored();
        logic [15:0] p;
        p = 16'h0015;
        do_load(p, 5'd6, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (signal !== p[i] || busy !== 1'b1)
                $display("FAIL ignored_bit%0d: got s=%b b=%b want s=%b b=1",
                         i, signal, busy, p[i]);
            else n_pass++;
            if (i == 1) begin
                load       = 1'b1;
                start      = 1'b1;
                pattern_in = 16'hFFFF;
                length_in  = 5'd2;
            end
            tick();
            load  = 1'b0;
            start = 1'b0;
        end
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL ignored_done: got d=%b b=%b want 1 0", done, busy);
        else n_pass++;
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_total++;
        if (busy !== 1'b0 || signal !== 1'b0)
            $display("FAIL start_stop_idle: got b=%b s=%b want 0 0", busy, signal);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        do_load(16'hFFFF, 5'd0, 8'd1, 1'b0);
        do_start();
        for (int i = 0; i < 6; i++) tick();
        n_total++;
        if (bit_index !== 5'd3 || busy !== 1'b1 || signal !== 1'b1)
            $display("FAIL arst_pre: got idx=%0d b=%b s=%b want 3 1 1",
                     bit_index, busy, signal);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (signal !== 1'b0 || busy !== 1'b0 || bit_index !== 5'd0 || done !== 1'b0)
            $display("FAIL arst_async: got s=%b b=%b idx=%0d d=%b want 0 0 0 0",
                     signal, busy, bit_index, done);
        else n_pass++;
        #1;
        reset_n = 1'b1;
        do_start();
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (signal !== 1'b0 || busy !== 1'b1 || bit_index !== 5'(i))
                $display("FAIL arst_default_bit%0d: got s=%b b=%b idx=%0d want 0 1 %0d",
                         i, signal, busy, bit_index, i);
            else n_pass++;
            tick();
        end
        n_total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL arst_default_done: got d=%b b=%b want 1 0", done, busy);
        else n_pass++;
        tick();
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset_n    = 1'b0;
        load       = 1'b0;
        pattern_in = '0;
        length_in  = '0;
        div_in     = '0;
        repeat_in  = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        test_reset();
        test_oneshot();
        test_divider();
        test_repeat();
        test_length();
        test_ignored();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pattern_pulse_gen.md
Name: pattern_pulse_gen

Overview:
- Synthesizable, programmable serial pulse-pattern generator.
- Replaces fixed, delay-coded pulse stimulus with a registered, clock-synchronous pattern engine.
- Shifts out a loaded bit pattern on one output, LSB first; each bit is held for a programmable number of clock cycles.
- Supports one-shot or continuous (repeat) mode. Used as a stimulus/timing source for downstream sequential blocks and benches.

Parameters:
- PATTERN_W, 16: maximum pattern length in bits (>= 2).
- DIV_W, 8: width of the per-bit hold-count field.
- LEN_W, $clog2(PATTERN_W+1): width of the length field (derived; do not override).

Ports:
- clock: input, 1. Rising-edge clock.
- reset_n: input, 1. Asynchronous, active-low reset.
- load: input, 1. Latches pattern_in/length_in/div_in/repeat_in. Honoured only when idle.
- pattern_in: input, PATTERN_W. Pattern bits; bit 0 is emitted first.
- length_in: input, LEN_W. Number of bits to emit. 0 or any value >= PATTERN_W means PATTERN_W.
- div_in: input, DIV_W. Each bit is held div_in+1 cycles.
- repeat_in: input, 1. 1 = wrap continuously; 0 = one-shot.
- start: input, 1. Begins emission when idle.
- stop: input, 1. Aborts emission.
- signal: output, 1. Registered pattern output.
- busy: output, 1. High while RUN.
- done: output, 1. One-cycle pulse at normal one-shot completion.
- bit_index: output, LEN_W. Index of the bit currently driven (0 when idle).

Behaviour:
- Reset (reset_n low, asynchronous): signal=0, busy=0, done=0, bit_index=0, hold counter=0.
  - Config registers reset to pattern=0, length=0 (meaning full PATTERN_W), div=0, repeat=0.
  - State returns to IDLE. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, RUN. done is a registered one-cycle flag, not a separate state.
- IDLE:
  - signal=0, busy=0.
  - load=1 latches all config fields at the edge.
  - start=1 with stop=0 at edge k: enter RUN, bit_index=0, signal=pattern[0], busy=1, counter=div, all visible after edge k.
  - load and start in the same cycle: new config is latched and used for this run.
- RUN:
  - Counter decrements each cycle. When the counter is 0 at an edge, advance to the next bit and reload the counter with div.
  - Bit i is therefore held exactly div+1 cycles.
  - Last bit (index eff_len-1) expires, repeat=1: wrap to bit 0 with no gap cycle. done stays 0.
  - Last bit expires, repeat=0: go to IDLE, signal=0, busy=0, done=1 for exactly one cycle.
  - One-shot timing: with start at edge k, done is asserted after edge k+eff_len*(div+1).
  - stop=1 at any edge: go to IDLE next edge, signal=0, busy=0, bit_index=0, done=0. stop overrides natural completion in the same cycle.
  - load and start are ignored while RUN. Config is stable for the whole run.
- Effective length: eff_len = PATTERN_W if length==0 or length>=PATTERN_W, else length.
  - length=1 emits a single bit.
- start and stop both high in IDLE: stop wins, remain IDLE.
- All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- One-shot, 6 bits: load pattern=0x0015, length=6, div=0, repeat=0; start at edge k.
  - Required: signal = 1,0,1,0,1,0 on cycles k..k+5.
  - Required: signal=0 and done=1 for one cycle after edge k+6, then done=0, busy=0.
- Divider: same pattern with div=3.
  - Required: each bit held 4 cycles.
  - Required: done after edge k+24.
  - Required: bit_index steps 0..5 every 4 cycles.
- Repeat: pattern=0x0005, length=3, div=0, repeat=1.
  - Required: signal = 1,0,1,1,0,1,... with no gap and no done.
  - Then stop → signal=0, busy=0 next cycle, done never asserted.
- Length edge cases:
  - length=0, pattern=0xA5A5: emits all 16 bits LSB first.
  - length=20 behaves identically to length=0.
  - length=1, pattern=1: one high cycle, then done.
- Ignored inputs: load a new pattern and pulse start mid-run.
  - Required: the output sequence is unchanged.
  - Required: a start with stop in IDLE leaves busy=0.
- Asynchronous reset mid-run: drive reset_n low between clock edges during bit 3.
  - Required: signal/busy/bit_index go to 0 immediately, without a clock edge.
  - Required: after release, start emits the reset-default config (16 zero bits, div=0).
